mat_mul_arbiter: RTL and testbench

Shares one mat4 x mat4 multiplier (start/done datapath, operands a and b, result q) between PORTS independent requesters, e.g. the vertex-transform setup, the camera/projection composer and the host-command path.
- Arbitration is round-robin with valid/ready request and response handshakes.
- Operands are registered for the full multiply, and the result is held until the winning requester accepts it.
- Sits between the gfx command front-end clients and the single multiplier instance.

---
 rtl/mat_mul_arbiter_if.sv | 29 ++
 rtl/mat_mul_arbiter.sv | 111 +++++++++++
 tb/tb_mat_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_mul_arbiter_if.sv
// Requester and multiplier-side signals of the shared mat4 multiplier arbiter.
// mat4 is 16 elements of MAT_W/16 bits, element (r,c) at index r*4+c.
interface mat_mul_arbiter_if #(
   parameter int PORTS = 4,
   parameter int MAT_W = 256
);
   logic [PORTS-1:0]            req_valid;
   logic [PORTS-1:0]            req_ready;
   logic [PORTS-1:0][MAT_W-1:0] req_a;
   logic [PORTS-1:0][MAT_W-1:0] req_b;
   logic [PORTS-1:0]            resp_valid;
   logic [PORTS-1:0]            resp_ready;
   logic [MAT_W-1:0]            resp_q;
   logic                        mul_start;
   logic [MAT_W-1:0]            mul_a;
   logic [MAT_W-1:0]            mul_b;
   logic                        mul_done;
   logic [MAT_W-1:0]            mul_q;

   modport slave (
      input  req_valid, req_a, req_b, resp_ready, mul_done, mul_q,
      output req_ready, resp_valid, resp_q, mul_start, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, resp_ready, mul_done, mul_q,
      input  req_ready, resp_valid, resp_q, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/mat_mul_arbiter.sv
// Round-robin share of one mat4 multiplier: min 4 cycles/op (grant, issue, wait, resp);
// the result is held on resp_q until the granted port raises resp_ready.
module mat_mul_arbiter #(
   parameter int PORTS = 4,
   parameter int LAT_W = 16,
   parameter int MAT_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   mat_mul_arbiter_if.slave  bus,
   output logic              busy,
   output logic [LAT_W-1:0]  last_lat
);
   localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic [GW-1:0]    ptr;
   logic [GW-1:0]    grant;
   logic [GW-1:0]    win;
   logic [GW-1:0]    idx;
   logic             win_vld;
   logic [MAT_W-1:0] opa;
   logic [MAT_W-1:0] opb;
   logic [MAT_W-1:0] res;
   logic [LAT_W-1:0] lat_cnt;
   logic             start;
   logic [PORTS-1:0] rvld;

   function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input logic [GW-1:0] off);
      logic [GW:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= (GW+1)'(PORTS)) s = s - (GW+1)'(PORTS);
      return s[GW-1:0];
   endfunction

   // Scan from the far end so the last hit is the first port at or after ptr.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         idx = wrap_add(ptr, GW'(i));
         if (bus.req_valid[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   assign bus.req_ready  = (rst_n && state == IDLE && win_vld) ? (PORTS'(1) << win) : '0;
   assign bus.resp_valid = rvld;
   assign bus.resp_q     = res;
   assign bus.mul_start  = start;
   assign bus.mul_a      = opa;
   assign bus.mul_b      = opb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         grant    <= '0;
         opa      <= '0;
         opb      <= '0;
         res      <= '0;
         lat_cnt  <= '0;
         last_lat <= '0;
         start    <= 1'b0;
         rvld     <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  opa   <= bus.req_a[win];
                  opb   <= bus.req_b[win];
                  grant <= win;
                  start <= 1'b1;
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               start   <= 1'b0;
               lat_cnt <= LAT_W'(1);
               state   <= WAIT;
            end
            WAIT: begin
               if (bus.mul_done) begin
                  res      <= bus.mul_q;
                  last_lat <= lat_cnt;
                  rvld     <= PORTS'(1) << grant;
                  state    <= RESP;
               end else if (lat_cnt != '1) begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            RESP: begin
               if (bus.resp_ready[grant]) begin
                  rvld  <= '0;
                  busy  <= 1'b0;
                  ptr   <= wrap_add(grant, GW'(1));
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Directed bench for mat_mul_arbiter: 4 ports, 3-bit latency counter so saturation is reachable.
module tb_mat_mul_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic [2:0] last_lat;

   logic [3:0]        rv;
   logic [3:0]        rr;
   logic [3:0][255:0] ra;
   logic [3:0][255:0] rb;
   logic              mdl_done;
   logic              stray_done;
   logic [255:0]      mdl_q;
   logic [255:0]      ma;
   logic [255:0]      mb;
   int                pend;
   int                mdl_dly;
   int                checks;
   int                failures;
   int                sc [4] = '{2, 1, 3, 4};

   always #5 clk = ~clk;

   mat_mul_arbiter_if #(.PORTS(4), .MAT_W(256)) bus ();

   assign bus.req_valid  = rv;
   assign bus.resp_ready = rr;
   assign bus.req_a      = ra;
   assign bus.req_b      = rb;
   assign bus.mul_done   = mdl_done | stray_done;
   assign bus.mul_q      = mdl_q;

   mat_mul_arbiter #(.PORTS(4), .LAT_W(3), .MAT_W(256)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .last_lat (last_lat)
   );

   function automatic logic [255:0] diag(input int s);
      logic [255:0] m;
      m = '0;
      for (int r = 0; r < 4; r++) m[(r*5)*16 +: 16] = 16'(s);
      return m;
   endfunction

   function automatic logic [255:0] scaled(input int s);
      logic [255:0] m;
      for (int k = 0; k < 16; k++) m[k*16 +: 16] = 16'(s * (k + 1));
      return m;
   endfunction

   function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] q;
      logic [15:0]  acc;
      q = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc = acc + a[(r*4+k)*16 +: 16] * b[(k*4+c)*16 +: 16];
            q[(r*4+c)*16 +: 16] = acc;
         end
      return q;
   endfunction

   // Multiplier stand-in: done pulses mdl_dly cycles after the cycle carrying mul_start.
   always @(negedge clk) begin
      if (mdl_done) mdl_done = 1'b0;
      if (bus.mul_start) begin
         ma   = bus.mul_a;
         mb   = bus.mul_b;
         pend = mdl_dly;
      end else if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            mdl_done = 1'b1;
            mdl_q    = matmul(ma, mb);
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_mul_start", bus.mul_start, 0);
      check("rst_busy", busy, 0);
      check("rst_last_lat", last_lat, 0);
      check("rst_resp_q", bus.resp_q, 0);
      check("rst_mul_a", bus.mul_a, 0);
      check("rst_mul_b", bus.mul_b, 0);
      rv = '0;
      rr = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
   task automatic run_op(input logic [3:0] vmask, input int g, input int lat, input int hold, input bit stray);
      logic [3:0] oh;
      int n;
      oh = 4'b1 << g;
      rv = vmask;
      #1;
      check("grant_req_ready", bus.req_ready, oh);
      @(negedge clk);
      check("issue_mul_start", bus.mul_start, 1);
      check("issue_busy", busy, 1);
      check("issue_req_ready", bus.req_ready, 0);
      check("issue_mul_a", bus.mul_a, diag(sc[g]));
      check("issue_mul_b", bus.mul_b, scaled(1));
      @(negedge clk);
      if (stray) begin
         ra[g] = ~ra[g];
         rb[g] = '0;
      end
      n = 0;
      while (bus.resp_valid == 4'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (stray) begin
         check("wait_mul_a_stable", bus.mul_a, diag(sc[g]));
         check("wait_mul_b_stable", bus.mul_b, scaled(1));
         ra[g] = diag(sc[g]);
         rb[g] = scaled(1);
      end
      check("resp_valid", bus.resp_valid, oh);
      check("resp_q", bus.resp_q, scaled(sc[g]));
      check("last_lat", last_lat, lat);
      for (int k = 0; k < hold; k++) begin
         rr = (k % 2 == 0) ? ~oh : 4'b0;
         @(negedge clk);
         check("hold_resp_valid", bus.resp_valid, oh);
         check("hold_resp_q", bus.resp_q, scaled(sc[g]));
         check("hold_req_ready", bus.req_ready, 0);
      end
      rr = '0;
      if (stray) begin
         stray_done = 1'b1;
         @(negedge clk);
         stray_done = 1'b0;
         check("stray_resp_valid", bus.resp_valid, oh);
         check("stray_resp_q", bus.resp_q, scaled(sc[g]));
         check("stray_last_lat", last_lat, lat);
      end
      rr = oh;
      @(negedge clk);
      rr = '0;
      check("accept_resp_valid", bus.resp_valid, 0);
      check("accept_busy", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      rv = '0;
      rr = '0;
      mdl_done = 1'b0;
      stray_done = 1'b0;
      mdl_q = '0;
      ma = '0;
      mb = '0;
      pend = 0;
      mdl_dly = 3;
      for (int p = 0; p < 4; p++) begin
         ra[p] = diag(sc[p]);
         rb[p] = scaled(1);
      end
      @(negedge clk);
      do_reset();

      // Single requester, identity times M.
      mdl_dly = 3;
      run_op(4'b0010, 1, 3, 0, 1'b0);

      // Ports 0 and 2 contend from ptr=0.
      do_reset();
      mdl_dly = 1;
      run_op(4'b0101, 0, 1, 0, 1'b0);
      run_op(4'b0101, 2, 1, 0, 1'b0);
      run_op(4'b0101, 0, 1, 0, 1'b0);

      // All ports requesting continuously.
      do_reset();
      mdl_dly = 2;
      for (int k = 0; k < 8; k++) run_op(4'b1111, k % 4, 2, 0, 1'b0);

      // Response held off for 10 cycles while other resp_ready bits toggle.
      mdl_dly = 4;
      run_op(4'b0011, 0, 4, 10, 1'b0);

      // Stray done in IDLE, operand churn in WAIT, stray done in RESP, latency saturation.
      rv = '0;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      check("idle_stray_busy", busy, 0);
      check("idle_stray_resp_valid", bus.resp_valid, 0);
      check("idle_stray_last_lat", last_lat, 4);
      mdl_dly = 10;
      run_op(4'b0100, 2, 7, 0, 1'b1);

      // Reset during WAIT; the abandoned multiply's done lands in IDLE.
      rv = 4'b0100;
      mdl_dly = 5;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", busy, 1);
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("late_done_busy", busy, 0);
         check("late_done_resp_valid", bus.resp_valid, 0);
      end
      check("late_done_last_lat", last_lat, 0);
      check("late_done_resp_q", bus.resp_q, 0);
      mdl_dly = 2;
      run_op(4'b1001, 0, 2, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
